// File: rtl/noc_sa_pkg.sv
// Shared constants, the grant-code type and the 7->1 wrap helper for the switch allocator.
package noc_sa_pkg;

  localparam int unsigned NPORTS = 7;
  localparam int unsigned CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_NONE = 3'b000;
  localparam code_t CODE_P1   = 3'b001;
  localparam code_t CODE_P2   = 3'b010;
  localparam code_t CODE_P3   = 3'b011;
  localparam code_t CODE_P4   = 3'b100;
  localparam code_t CODE_P5   = 3'b101;
  localparam code_t CODE_P6   = 3'b110;
  localparam code_t CODE_P7   = 3'b111;

  function automatic code_t next_code(input code_t c);
    return (c == CODE_P7) ? CODE_P1 : code_t'(c + 3'd1);
  endfunction

endpackage

// File: rtl/rr_arb7.sv
// Per-output round-robin arbiter with wormhole lock; grant is combinational, state updates on clk.
module rr_arb7
  import noc_sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] tail,
  input  logic              rdy,
  output code_t             grant,
  output logic              locked
);

  code_t ptr;
  code_t owner;
  logic  lock;
  code_t scan_code;
  logic  [2:0] idx;
  logic  grant_tail;

  // Scan ptr, ptr+1, ... wrapping 7->1; first requester found wins.
  always_comb begin
    scan_code = CODE_NONE;
    idx       = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx = 3'((32'(ptr) + k - 1) % NPORTS);
      if (scan_code == CODE_NONE && req[idx]) scan_code = code_t'(idx + 3'd1);
    end
  end

  always_comb begin
    if (!rst_n)
      grant = CODE_NONE;
    else if (lock)
      grant = (req[owner - 3'd1] && rdy) ? owner : CODE_NONE;
    else
      grant = rdy ? scan_code : CODE_NONE;
  end

  assign grant_tail = (grant != CODE_NONE) && tail[grant - 3'd1];
  assign locked     = lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= CODE_P1;
      owner <= CODE_P1;
      lock  <= 1'b0;
    end else if (grant != CODE_NONE) begin
      if (lock) begin
        if (grant_tail) begin
          lock <= 1'b0;
          ptr  <= next_code(owner);
        end
      end else if (grant_tail) begin
        ptr <= next_code(grant);
      end else begin
        lock  <= 1'b1;
        owner <= grant;
      end
    end
  end

endmodule

// File: rtl/switch_alloc7.sv
// Seven-output switch allocator: per-output request decode, independent arbiters, pop strobes.
module switch_alloc7
  import noc_sa_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS*CODE_W-1:0] dst,
  input  logic [NPORTS-1:0]        tail,
  input  logic [NPORTS-1:0]        out_rdy,
  output logic [NPORTS*CODE_W-1:0] sa_grant,
  output logic [NPORTS-1:0]        in_gnt,
  output logic [NPORTS-1:0]        lock_vec
);

  logic [NPORTS-1:0] out_req [NPORTS];
  code_t             grants  [NPORTS];

  always_comb begin
    for (int unsigned o = 0; o < NPORTS; o++) begin
      out_req[o] = '0;
      for (int unsigned i = 0; i < NPORTS; i++)
        out_req[o][i] = req[i] && (dst[CODE_W*i +: CODE_W] == code_t'(o + 1));
    end
  end

  // An input targets a single output, so OR-ing matches across outputs yields its pop strobe.
  always_comb begin
    in_gnt = '0;
    for (int unsigned o = 0; o < NPORTS; o++)
      for (int unsigned i = 0; i < NPORTS; i++)
        if (grants[o] == code_t'(i + 1)) in_gnt[i] = 1'b1;
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_out
    rr_arb7 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (out_req[g]),
      .tail   (tail),
      .rdy    (out_rdy[g]),
      .grant  (grants[g]),
      .locked (lock_vec[g])
    );
    assign sa_grant[CODE_W*g +: CODE_W] = grants[g];
  end

endmodule

// File: tb/tb_switch_alloc7.sv
// Bench for switch_alloc7: directed scenarios with literal expectations plus randomized traffic vs. a behavioural model.
module tb_switch_alloc7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  req, tail, out_rdy;
  logic [20:0] dst;
  logic [20:0] sa_grant;
  logic [6:0]  in_gnt, lock_vec;

  switch_alloc7 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .dst      (dst),
    .tail     (tail),
    .out_rdy  (out_rdy),
    .sa_grant (sa_grant),
    .in_gnt   (in_gnt),
    .lock_vec (lock_vec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per-output pointer, lock flag, owner (all as plain port numbers 1..7)
  int mptr [1:7];
  int mlock[1:7];
  int mown [1:7];
  int eg   [1:7];
  int sticky_dst[1:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wants(int i, int o);
    return req[i-1] && (int'(dst[3*i-3 +: 3]) == o);
  endfunction

  function automatic int gcode(int o);
    return int'(sa_grant[3*o-3 +: 3]);
  endfunction

  task automatic set_dst(input int i, input int c);
    dst[3*i-3 +: 3] = c[2:0];
  endtask

  task automatic model_reset();
    for (int o = 1; o <= 7; o++) begin
      mptr[o] = 1; mlock[o] = 0; mown[o] = 1;
    end
  endtask

  task automatic model_eval();
    for (int o = 1; o <= 7; o++) begin
      eg[o] = 0;
      if (rst_n === 1'b1 && out_rdy[o-1]) begin
        if (mlock[o] != 0) begin
          if (wants(mown[o], o)) eg[o] = mown[o];
        end else begin
          for (int k = 0; k < 7; k++) begin
            int c;
            c = ((mptr[o] - 1 + k) % 7) + 1;
            if (eg[o] == 0 && wants(c, o)) eg[o] = c;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    if (rst_n !== 1'b1) begin
      model_reset();
    end else begin
      for (int o = 1; o <= 7; o++) begin
        if (eg[o] != 0) begin
          if (tail[eg[o]-1]) begin
            mlock[o] = 0;
            mptr[o]  = (eg[o] % 7) + 1;
          end else if (mlock[o] == 0) begin
            mlock[o] = 1;
            mown[o]  = eg[o];
          end
        end
      end
    end
  endtask

  // Compare DUT against the model for the inputs currently applied.
  task automatic eval_check(input string tag);
    logic [20:0] exp_g;
    logic [6:0]  exp_in, exp_lk;
    #1;
    model_eval();
    exp_g = '0; exp_in = '0; exp_lk = '0;
    for (int o = 1; o <= 7; o++) begin
      exp_g[3*o-3 +: 3] = eg[o][2:0];
      if (eg[o] != 0) exp_in[eg[o]-1] = 1'b1;
      if (rst_n === 1'b1 && mlock[o] != 0) exp_lk[o-1] = 1'b1;
    end
    chk({tag, " sa_grant"}, 32'(sa_grant), 32'(exp_g));
    chk({tag, " in_gnt"},   32'(in_gnt),   32'(exp_in));
    chk({tag, " lock_vec"}, 32'(lock_vec), 32'(exp_lk));
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rr_exp[4];
    int wh_exp[4];
    int wh_lk[4];
    rr_exp = '{2, 5, 7, 2};
    wh_exp = '{4, 4, 4, 6};
    wh_lk  = '{0, 1, 1, 0};

    rst_n = 1'b0; req = 7'h7F; tail = '1; out_rdy = '1;
    dst = 21'h0;
    for (int i = 1; i <= 7; i++) set_dst(i, (i % 7) + 1);
    model_reset();

    // Reset with everything requesting
    @(negedge clk);
    eval_check("reset");
    chk("reset sa_grant lit", 32'(sa_grant), 0);
    chk("reset in_gnt lit",   32'(in_gnt),   0);
    chk("reset lock_vec lit", 32'(lock_vec), 0);
    advance();
    rst_n = 1'b1; req = '0;
    eval_check("idle");
    advance();

    // Round-robin among inputs 2,5,7 on output 3
    dst = '0; set_dst(2, 3); set_dst(5, 3); set_dst(7, 3);
    req = 7'b1010010; tail = '1;
    for (int n = 0; n < 4; n++) begin
      eval_check("rr");
      chk("rr out3 code", 32'(gcode(3)), 32'(rr_exp[n]));
      advance();
    end

    // Wormhole: input 4 holds output 1 for 3 flits, input 6 waits
    dst = '0; set_dst(4, 1); set_dst(6, 1);
    req = 7'b0101000;
    for (int n = 0; n < 4; n++) begin
      tail = 7'b0100000;
      if (n >= 2) tail[3] = 1'b1;
      eval_check("worm");
      chk("worm out1 code", 32'(gcode(1)), 32'(wh_exp[n]));
      chk("worm lock1", 32'(lock_vec[0]), 32'(wh_lk[n]));
      advance();
    end

    // Backpressure on locked output 2 owned by input 3
    dst = '0; set_dst(3, 2); req = 7'b0000100; tail = '0; out_rdy = '1;
    eval_check("bp head");
    chk("bp head code", 32'(gcode(2)), 3);
    advance();
    out_rdy[1] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      eval_check("bp stall");
      chk("bp stall code", 32'(gcode(2)), 0);
      chk("bp stall lock", 32'(lock_vec[1]), 1);
      advance();
    end
    out_rdy = '1; tail[2] = 1'b1;
    eval_check("bp resume");
    chk("bp resume code", 32'(gcode(2)), 3);
    advance();
    eval_check("bp after");
    chk("bp released", 32'(lock_vec[1]), 0);
    advance();

    // Every input to a distinct output
    for (int i = 1; i <= 7; i++) set_dst(i, 8 - i);
    req = '1; tail = '1; out_rdy = '1;
    eval_check("par");
    for (int o = 1; o <= 7; o++) chk("par code", 32'(gcode(o)), 32'(8 - o));
    chk("par in_gnt", 32'(in_gnt), 32'h7F);
    advance();

    // Async reset while output 5 is locked
    dst = '0; set_dst(2, 5); req = 7'b0000010; tail = '0;
    eval_check("ar head");
    chk("ar head code", 32'(gcode(5)), 2);
    advance();
    eval_check("ar locked");
    chk("ar lock5", 32'(lock_vec[4]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar sa_grant", 32'(sa_grant), 0);
    chk("ar lock_vec", 32'(lock_vec), 0);
    chk("ar in_gnt",   32'(in_gnt),   0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_dst(3, 5); set_dst(7, 5); req = 7'b1000110; tail = '1;
    eval_check("ar fresh");
    chk("ar fresh code", 32'(gcode(5)), 2);
    advance();
    req = 7'b1000100;
    eval_check("ar next");
    chk("ar next code", 32'(gcode(5)), 3);
    advance();
    eval_check("ar third");
    chk("ar third code", 32'(gcode(5)), 7);
    advance();

    // Randomized traffic with sticky destinations so packets make progress
    for (int i = 1; i <= 7; i++) sticky_dst[i] = $urandom_range(0, 7);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 1; i <= 7; i++) begin
        if ($urandom_range(0, 7) == 0) sticky_dst[i] = $urandom_range(0, 7);
        set_dst(i, sticky_dst[i]);
        req[i-1]  = ($urandom_range(0, 3) != 0);
        tail[i-1] = ($urandom_range(0, 2) == 0);
      end
      out_rdy = 7'($urandom | $urandom);
      rst_n   = ($urandom_range(0, 299) != 0);
      eval_check("rand");
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_alloc7.md
Name: switch_alloc7

Overview:
- Seven-output switch allocator for the 7-port router.
- Each cycle it arbitrates flit requests from 7 input ports to 7 output ports using per-output round-robin and wormhole packet locking.
- Emits one 3-bit grant code per output. The pop-control mapping and the crossbar consume these codes directly.
- Sits between the input-buffer head-flit decode and the pop-control/crossbar stage.

Parameters:
- NPORTS, 7, number of input and output ports. Fixed at 7, because the grant code is 3 bits.
- CODE_W, 3, grant/destination code width. Code k in 1..7 means port k; 0 means none.

Ports:
- clk  in  1  router clock
- rst_n  in  1  asynchronous active-low reset
- req  in  7  bit i-1: input port i has a valid head-of-queue flit
- dst  in  21  bits [3i-1:3i-3]: destination output code of input i's flit; 0 is ignored
- tail  in  7  bit i-1: input i's flit is a tail or single-flit packet
- out_rdy  in  7  bit o-1: output o (downstream credit) can accept a flit this cycle
- sa_grant  out  21  bits [3o-1:3o-3]: code of the input granted to output o; 0 = none
- in_gnt  out  7  bit i-1: input i was granted somewhere this cycle (pop strobe)
- lock_vec  out  7  bit o-1: output o is currently locked to a packet

Behaviour:
- Decided: one clock; reset is asynchronous and active-low.
- Reset state (async, immediate):
  - all pointers = 1, all locks cleared.
  - sa_grant = 0, in_gnt = 0, lock_vec = 0 while rst_n is low.
- Grant timing: sa_grant and in_gnt are combinational from current inputs plus registered state (zero-cycle allocation). State updates on the rising clk edge.
- Request filter: input i targets output o iff req[i] && dst_i == o.
  - dst_i = 0 never requests.
  - Each input targets at most one output, so it wins at most one output; in_gnt[i] is the OR over outputs.
- Per-output state: ptr_o (code 1..7), lock_o (1 bit), owner_o (code 1..7).
- Output o, locked (lock_o = 1):
  - Grant owner_o iff owner_o targets o and out_rdy[o]; all other requesters are blocked.
  - If granted and tail: clear lock_o, set ptr_o = owner_o + 1 (7 wraps to 1).
  - If granted and not tail: hold the lock.
  - Idle or stalled cycles (owner drops req, or out_rdy low): hold lock and owner; no grant.
- Output o, unlocked:
  - If out_rdy[o] and any requester: winner = first requester scanning ptr_o, ptr_o+1, ... with wrap 7→1.
  - Winner with tail = 1 (single flit): ptr_o = winner + 1, stays unlocked.
  - Winner with tail = 0 (head): lock_o = 1, owner_o = winner; ptr unchanged until the tail.
  - out_rdy[o] = 0 or no requester: no grant, state unchanged.
- Simultaneous events:
  - All 7 outputs arbitrate independently in the same cycle.
  - An input whose packet holds output A is unaffected by other outputs.
  - A lock release and a new head for the same output cannot both be granted in the same cycle; the new head waits one cycle.
- Reset mid-packet: locks drop, pointers return to 1. Upstream is responsible for flushing partial packets.
- No starvation: each packet completion moves its output's pointer past the winner.

Decomposition:
- Package noc_sa_pkg:
  - NPORTS, CODE_W.
  - CODE_NONE = 3'b000 and the port codes 3'b001..3'b111.
  - A function next_code(c) implementing the 7→1 wrap.
- Sub-module rr_arb7: one per output, generate-instantiated 7 times.
  - Inputs: 7-bit request vector, tail vector, out_rdy bit.
  - Holds ptr, lock and owner; outputs a 3-bit grant code.
- Top level: builds the per-output request vectors from req/dst, concatenates the grants, ORs in_gnt.

Test Plan:
- Reset then idle: rst_n low, with req = 7'h7F held → sa_grant = 0, in_gnt = 0, lock_vec = 0.
- Round-robin fairness: inputs 2, 5, 7 all send single flits (tail = 1) to output 3 every cycle, out_rdy = all 1s → output-3 grant codes are 2, 5, 7, 2, ... (pointer starts at 1).
- Wormhole lock: input 4 sends head then body to output 1, input 6 also requests output 1 → grants 4, 4, 4 while lock_vec[0] = 1; tail on cycle 3 → next cycle grant 6, lock_vec[0] = 0.
- Backpressure: locked output 2 with out_rdy[1] = 0 for 3 cycles → grant 0, lock and owner held; out_rdy[1] = 1 → the owner resumes.
- Parallel outputs: input i sends a single flit to output 8-i for all i → all 7 grants nonzero in one cycle (output 7 gets code 1, ..., output 1 gets code 7), in_gnt = 7'h7F.
- Async reset mid-packet: rst_n pulsed low between clk edges while output 5 is locked → lock_vec and grants go to 0 immediately; after release, a fresh arbitration starts from pointer 1.
